// File: rtl/fs_det_pkg.sv
// fs_det_pkg: shared types and constants for the LRCK period detector.
//   fs_code_e  - 3-bit sample-rate code reported on fs_code_o
//   state_e    - detector FSM states
//   NOM_*      - nominal LRCK periods in clk_i cycles at 24.576 MHz
//   CLS_TOL    - half-width of each classification window
//   classify() - maps a measured period onto fs_code_e
package fs_det_pkg;

    typedef enum logic [2:0] {
        FS_UNKNOWN = 3'd0,
        FS_32K     = 3'd1,
        FS_44K1    = 3'd2,
        FS_48K     = 3'd3,
        FS_88K2    = 3'd4,
        FS_96K     = 3'd5,
        FS_176K4   = 3'd6,
        FS_192K    = 3'd7
    } fs_code_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEASURE,
        ST_LOCKED
    } state_e;

    localparam int unsigned CLS_TOL    = 3;
    localparam int unsigned NOM_32K    = 768;
    localparam int unsigned NOM_44K1   = 557;
    localparam int unsigned NOM_48K    = 512;
    localparam int unsigned NOM_88K2   = 279;
    localparam int unsigned NOM_96K    = 256;
    localparam int unsigned NOM_176K4  = 139;
    localparam int unsigned NOM_192K   = 128;

    function automatic logic near(input int unsigned meas, input int unsigned nom);
        return (meas + CLS_TOL >= nom) && (meas <= nom + CLS_TOL);
    endfunction

    // Windows are disjoint, so the order of the tests does not matter.
    function automatic fs_code_e classify(input int unsigned meas);
        fs_code_e code;
        code = FS_UNKNOWN;
        if (near(meas, NOM_32K))   code = FS_32K;
        if (near(meas, NOM_44K1))  code = FS_44K1;
        if (near(meas, NOM_48K))   code = FS_48K;
        if (near(meas, NOM_88K2))  code = FS_88K2;
        if (near(meas, NOM_96K))   code = FS_96K;
        if (near(meas, NOM_176K4)) code = FS_176K4;
        if (near(meas, NOM_192K))  code = FS_192K;
        return code;
    endfunction

endpackage

// File: rtl/fs_period_detector_if.sv
// fs_period_detector_if: result bus of the LRCK period detector.
//   period_o       - last locked period in clk_i cycles
//   period_valid_o - one-cycle pulse per captured measurement
//   lock_o         - measurement stable
//   fs_code_o      - sample-rate code (fs_det_pkg::fs_code_e)
//   timeout_o      - one-cycle pulse when LRCK is lost
// master: the detector drives the bus; slave: a consumer reads it.
interface fs_period_detector_if #(
    parameter int unsigned WIDTH = 10
);
    logic [WIDTH-1:0] period_o;
    logic             period_valid_o;
    logic             lock_o;
    logic [2:0]       fs_code_o;
    logic             timeout_o;

    modport master (output period_o, period_valid_o, lock_o, fs_code_o, timeout_o);
    modport slave  (input  period_o, period_valid_o, lock_o, fs_code_o, timeout_o);
endinterface

// File: rtl/sync_edge_det.sv
// sync_edge_det: 2-flop synchronizer followed by a registered rising-edge
// detector. rise_o pulses for one clk_i cycle, 3 cycles after d_i rises.
//   clk_i  - clock
//   rst_ni - synchronous active-low reset (clears all flops)
//   d_i    - asynchronous input
//   rise_o - rising-edge pulse
module sync_edge_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);
    logic s1_q, s2_q, prev_q, rise_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            rise_q <= s2_q & ~prev_q;
        end
    end

    assign rise_o = rise_q;
endmodule

// File: rtl/fs_period_detector.sv
// fs_period_detector: counts clk_i cycles per LRCK period, requires
// consecutive agreeing measurements before asserting lock, and classifies
// the locked period into a sample-rate code.
//   clk_i  - system clock (24.576 MHz nominal)
//   rst_ni - synchronous active-low reset
//   lrck_i - LR clock, asynchronous to clk_i
//   det_o  - result bus (period, valid pulse, lock, fs code, timeout pulse)
module fs_period_detector
    import fs_det_pkg::*;
#(
    parameter int unsigned WIDTH    = 10,
    parameter int unsigned TOL      = 2,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        lrck_i,
    fs_period_detector_if.master        det_o
);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic                   rise;
    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       prev_meas_q, prev_meas_d;
    logic [WIDTH-1:0]       period_q, period_d;
    logic [3:0]             match_q, match_d, match_inc;
    logic                   lock_q, lock_d;
    logic                   valid_q, valid_d;
    logic                   timeout_q, timeout_d;
    fs_code_e               fs_q, fs_d;
    logic signed [WIDTH:0]  diff;
    logic [WIDTH:0]         abs_diff;
    logic                   is_match, lock_reach, sat_hold, sat_enter;

    sync_edge_det u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (lrck_i),
        .rise_o (rise)
    );

    // The measurement is cnt_q itself in the rise cycle.
    assign diff       = $signed({1'b0, cnt_q}) - $signed({1'b0, prev_meas_q});
    assign abs_diff   = diff[WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    assign is_match   = 32'(abs_diff) <= TOL;
    assign match_inc  = (match_q == 4'd15) ? match_q : match_q + 4'd1;
    assign lock_reach = 32'(match_inc) >= LOCK_CNT - 1;
    assign sat_hold   = (cnt_q == CNT_MAX);
    assign sat_enter  = (cnt_q == CNT_MAX - CNT_ONE);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            prev_meas_q <= '0;
            period_q    <= '0;
            match_q     <= '0;
            lock_q      <= 1'b0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            fs_q        <= FS_UNKNOWN;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prev_meas_q <= prev_meas_d;
            period_q    <= period_d;
            match_q     <= match_d;
            lock_q      <= lock_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
            fs_q        <= fs_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        prev_meas_d = prev_meas_q;
        period_d    = period_q;
        match_d     = match_q;
        lock_d      = lock_q;
        fs_d        = fs_q;
        valid_d     = 1'b0;
        timeout_d   = 1'b0;

        if (rise)           cnt_d = CNT_ONE;
        else if (sat_hold)  cnt_d = cnt_q;
        else                cnt_d = cnt_q + CNT_ONE;

        if (rise) begin
            if (state_q == ST_IDLE || sat_hold) begin
                // First edge or edge after LRCK loss: partial period, no capture.
                state_d = ST_MEASURE;
                if (sat_hold) begin
                    lock_d  = 1'b0;
                    fs_d    = FS_UNKNOWN;
                    match_d = '0;
                end
            end else begin
                valid_d     = 1'b1;
                prev_meas_d = cnt_q;
                if (is_match) begin
                    match_d = match_inc;
                    if (state_q == ST_LOCKED || lock_reach) begin
                        state_d  = ST_LOCKED;
                        lock_d   = 1'b1;
                        period_d = cnt_q;
                        fs_d     = classify(32'(cnt_q));
                    end
                end else begin
                    state_d = ST_MEASURE;
                    match_d = '0;
                    lock_d  = 1'b0;
                    fs_d    = FS_UNKNOWN;
                end
            end
        end else if (sat_enter) begin
            // Fires only on the step into saturation; the held count cannot retrigger.
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
            match_d   = '0;
            lock_d    = 1'b0;
            fs_d      = FS_UNKNOWN;
        end
    end

    assign det_o.period_o       = period_q;
    assign det_o.period_valid_o = valid_q;
    assign det_o.lock_o         = lock_q;
    assign det_o.fs_code_o      = fs_q;
    assign det_o.timeout_o      = timeout_q;
endmodule
